// File: rtl/im_loader.sv
// Boot-time program loader: assembles a big-endian byte stream (word count
// followed by instruction words) and writes the words into the instruction
// memory from address 0, holding the CPU in reset until the load completes.
module im_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_waddr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           word_cnt
);

    // Memory depth, one bit wider than word_cnt so 2**32 compares cleanly.
    localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LEN  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            bcnt_q, bcnt_d;
    // Only the three earlier bytes of a word need storing; the fourth byte
    // is taken straight from s_data when the word completes.
    logic [23:0]           shift_q, shift_d;
    logic [31:0]           len_q, len_d;
    logic [31:0]           word_cnt_q, word_cnt_d;
    logic                  im_we_q, im_we_d;
    logic [ADDR_WIDTH-1:0] im_waddr_q, im_waddr_d;
    logic [31:0]           im_wdata_q, im_wdata_d;
    logic                  cpu_run_q, cpu_run_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  xfer_s;
    logic                  last_byte_s;
    logic [31:0]           word_s;

    // Handshake: ready depends on state only, never on s_valid.
    always_comb begin
        s_ready     = (state_q == S_LEN) || (state_q == S_DATA);
        xfer_s      = s_valid && s_ready;
        last_byte_s = (bcnt_q == 2'd3);
        word_s      = {shift_q, s_data};
    end

    // Next-state and registered-output computation for the load sequencer.
    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        im_we_d    = 1'b0;
        im_waddr_d = im_waddr_q;
        im_wdata_d = im_wdata_q;
        cpu_run_d  = cpu_run_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LEN;
                    bcnt_d     = 2'd0;
                    word_cnt_d = 32'd0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    cpu_run_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEN: begin
                if (xfer_s) begin
                    shift_d = word_s[23:0];
                    bcnt_d  = bcnt_q + 2'd1;
                    if (last_byte_s) begin
                        len_d = word_s;
                        if ({1'b0, word_s} > DEPTH) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = 1'b0;
                        end
                        if (word_s == 32'd0) begin
                            // Empty program: release the CPU straight away.
                            state_d   = S_DONE;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                            cpu_run_d = 1'b1;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_LEN;
                    end
                end else begin
                    state_d = S_LEN;
                end
            end
            S_DATA: begin
                if (xfer_s) begin
                    shift_d = word_s[23:0];
                    bcnt_d  = bcnt_q + 2'd1;
                    if (last_byte_s) begin
                        word_cnt_d = word_cnt_q + 32'd1;
                        // Words beyond the memory are consumed but dropped.
                        if ({1'b0, word_cnt_q} < DEPTH) begin
                            im_we_d    = 1'b1;
                            im_waddr_d = word_cnt_q[ADDR_WIDTH-1:0];
                            im_wdata_d = word_s;
                        end else begin
                            im_we_d = 1'b0;
                        end
                        if ((word_cnt_q + 32'd1) == len_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d    = S_LEN;
                    bcnt_d     = 2'd0;
                    word_cnt_d = 32'd0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    cpu_run_d  = 1'b0;
                end else if (!done_q) begin
                    // Final write is on the bus this cycle; status follows.
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    cpu_run_d = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            bcnt_q     <= 2'd0;
            shift_q    <= 24'd0;
            len_q      <= 32'd0;
            word_cnt_q <= 32'd0;
            im_we_q    <= 1'b0;
            im_waddr_q <= {ADDR_WIDTH{1'b0}};
            im_wdata_q <= 32'd0;
            cpu_run_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            im_we_q    <= im_we_d;
            im_waddr_q <= im_waddr_d;
            im_wdata_q <= im_wdata_d;
            cpu_run_q  <= cpu_run_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Drive ports from the registers.
    always_comb begin
        im_we    = im_we_q;
        im_waddr = im_waddr_q;
        im_wdata = im_wdata_q;
        cpu_run  = cpu_run_q;
        busy     = busy_q;
        done     = done_q;
        err      = err_q;
        word_cnt = word_cnt_q;
    end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader with a 4-word memory so overflow is reachable.
module tb_im_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    s_data = 8'd0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          im_we;
    logic [AW-1:0] im_waddr;
    logic [31:0]   im_wdata;
    logic          cpu_run;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   word_cnt;

    im_loader #(.ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
        .cpu_run(cpu_run), .busy(busy), .done(done), .err(err),
        .word_cnt(word_cnt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            due;
    } wr_t;
    wr_t exp_q[$];

    logic [31:0] wbuf[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every write on the memory port must match the next expected one.
    always @(negedge clock) begin
        wr_t e;
        if (im_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %0h data %0h at cycle %0d", im_waddr, im_wdata, cyc);
            end else begin
                e = exp_q.pop_front();
                check("waddr", {30'd0, im_waddr}, {30'd0, e.addr});
                check("wdata", im_wdata, e.data);
                check("wcycle", cyc, e.due);
            end
        end
    end

    // Offer one byte until accepted; returns the cycle its effects should show.
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit with_start, output int due);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        due   = 0;
        while (!acc) begin
            @(negedge clock);
            if (gaps && ($urandom_range(0, 1) == 0)) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = b;
                start   = with_start;
            end
            acc = s_valid && s_ready;
            @(posedge clock);
            #1;
            s_valid = 1'b0;
            start   = 1'b0;
            due     = cyc;
            guard++;
            if (!acc && guard > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL byte_timeout: byte %0h never accepted", b);
                acc = 1'b1;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps, input bit with_start, output int due);
        logic [31:0] v;
        v = w;
        for (int k = 0; k < 4; k++) begin
            send_byte(v[31:24], gaps, with_start && (k == 0), due);
            v = v << 8;
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_cpu_run", cpu_run, 1'b0);
        check("start_done", done, 1'b0);
        check("start_err", err, 1'b0);
        check("start_word_cnt", word_cnt, 32'd0);
    endtask

    // Full session from start; words come from wbuf (length n).
    task automatic run_session(input logic [31:0] n, input bit gaps, input bit poke);
        int due;
        pulse_start();
        send_word(n, gaps, 1'b0, due);
        @(negedge clock);
        check("len_err", err, (n > DEPTH) ? 32'd1 : 32'd0);
        if (n == 0) begin
            check("zero_done", done, 1'b1);
            check("zero_cpu_run", cpu_run, 1'b1);
            check("zero_busy", busy, 1'b0);
            check("zero_s_ready", s_ready, 1'b0);
            check("zero_word_cnt", word_cnt, 32'd0);
        end else begin
            for (int i = 0; i < n; i++) begin
                send_word(wbuf[i], gaps, poke && (i > 0), due);
                if (i < DEPTH) begin
                    exp_q.push_back('{addr: i[AW-1:0], data: wbuf[i], due: due});
                end
                @(negedge clock);
                check("word_cnt_step", word_cnt, i + 1);
                if (i + 1 == n) begin
                    check("pre_done", done, 1'b0);
                    check("last_s_ready", s_ready, 1'b0);
                    @(negedge clock);
                    check("end_done", done, 1'b1);
                    check("end_cpu_run", cpu_run, 1'b1);
                    check("end_busy", busy, 1'b0);
                    check("end_s_ready", s_ready, 1'b0);
                    check("end_err", err, (n > DEPTH) ? 32'd1 : 32'd0);
                    check("end_word_cnt", word_cnt, n);
                    check("end_pending", exp_q.size(), 32'd0);
                end else if (poke) begin
                    start = 1'b1;
                    @(negedge clock);
                    start = 1'b0;
                    check("ignored_start_cnt", word_cnt, i + 1);
                    check("ignored_start_busy", busy, 1'b1);
                end else begin
                    check("mid_busy", busy, 1'b1);
                end
            end
        end
    endtask

    initial begin
        int due;
        int n;

        // Reset state
        @(negedge clock);
        check("rst_im_we", im_we, 1'b0);
        check("rst_cpu_run", cpu_run, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_word_cnt", word_cnt, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Basic load, then the same stream with gaps
        wbuf = '{32'h24010005, 32'h08000C00};
        run_session(32'd2, 1'b0, 1'b0);
        run_session(32'd2, 1'b1, 1'b0);

        // Zero length
        run_session(32'd0, 1'b1, 1'b0);

        // Overflow: 6 words into a 4-word memory, with ignored starts
        wbuf = '{32'h11111111, 32'h22222222, 32'h33333333,
                 32'h44444444, 32'h55555555, 32'h66666666};
        run_session(32'd6, 1'b0, 1'b1);

        // Reset in the middle of word 1
        pulse_start();
        send_word(32'd3, 1'b0, 1'b0, due);
        send_word(32'hCAFEF00D, 1'b0, 1'b0, due);
        exp_q.push_back('{addr: 2'd0, data: 32'hCAFEF00D, due: due});
        send_byte(8'hAB, 1'b0, 1'b0, due);
        send_byte(8'hCD, 1'b0, 1'b0, due);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("arst_im_we", im_we, 1'b0);
        check("arst_cpu_run", cpu_run, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_word_cnt", word_cnt, 32'd0);
        check("arst_s_ready", s_ready, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        wbuf = '{32'hDEADBEEF};
        run_session(32'd1, 1'b0, 1'b0);

        // Randomized sessions, each restarting from DONE
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(0, 7);
            wbuf.delete();
            for (int i = 0; i < n; i++) wbuf.push_back($urandom);
            run_session(n, $urandom_range(0, 1), $urandom_range(0, 1));
        end

        repeat (3) @(negedge clock);
        check("final_pending", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time program loader. It is the write side of the instruction memory that the single-cycle CPU reads.
- Accepts a byte stream over a valid/ready interface: a 4-byte big-endian word count N, then N big-endian 32-bit instruction words.
- Writes each assembled word into the instruction memory write port at consecutive word addresses starting at 0.
- Holds the CPU in reset until loading completes.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width; depth DEPTH = 2**ADDR_WIDTH words.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  single-cycle pulse that begins a load session.
- s_data  input  8  stream byte.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- im_waddr  output  ADDR_WIDTH  word address of the write.
- im_wdata  output  32  instruction word to write.
- cpu_run  output  1  1 releases the CPU; 0 holds the CPU in reset.
- busy  output  1  a load session is in progress.
- done  output  1  last session completed; sticky until the next start.
- err  output  1  length exceeded DEPTH; sticky until the next start.
- word_cnt  output  32  number of data words consumed in the current or last session.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0, so cpu_run=0 and the CPU is held. Byte counter, shift register, length register and word_cnt are cleared.
- States are IDLE, LEN, DATA and DONE.
- Byte transfer occurs when s_valid && s_ready. s_ready=1 combinationally in LEN and DATA, otherwise 0. One byte per cycle max. s_valid may be low in any cycle, and gaps do not disturb assembly.
- Assembly: a 2-bit byte counter and a 32-bit shift register, with the first byte as bits [31:24] (big-endian). The counter wraps 3->0 on the 4th byte.
- IDLE: on start, go to LEN. Clear done, err, word_cnt and the byte counter. Drive cpu_run=0 and busy=1 from the next cycle.
- LEN: on the 4th accepted byte, latch N.
  - N=0: go to DONE.
  - Otherwise go to DATA.
  - If N > DEPTH, err=1 in the next cycle.
- DATA, on the 4th accepted byte of a word at index i=word_cnt:
  - Next cycle: word_cnt=i+1.
  - Next cycle, if i < DEPTH: im_we=1, im_waddr=i[ADDR_WIDTH-1:0], im_wdata=the assembled word.
  - If i >= DEPTH: no write (word is discarded), but it is still consumed.
  - The write latency is exactly 1 cycle after the accepting edge, and im_we lasts exactly 1 cycle.
  - im_waddr and im_wdata are don't-care while im_we=0, but they hold their last values.
  - When i+1 == N, the state becomes DONE in the same cycle that the final im_we is high.
- DONE: busy=0, done=1, cpu_run=1. These rise in the cycle after the final im_we, or in the cycle after LEN completes when N=0. s_ready=0.
- start in DONE: treated as in IDLE (restart). cpu_run drops to 0 in the next cycle.
- start while busy (LEN or DATA): ignored.
- Simultaneous start and a byte transfer in LEN or DATA: the byte is processed and start is ignored.
- Reset mid-session: immediate return to IDLE with cpu_run=0. A partial word is discarded and no im_we is issued.
- word_cnt is 32-bit and counts discarded words too. N=2**32-1 must not overflow before completion.
- No combinational path from s_valid to any output except none; s_ready depends only on state.

Test Plan:
- Basic load: after reset, pulse start, send 00 00 00 02 | 24 01 00 05 | 08 00 0C 00 -> im_we pulses twice:
  - (addr 0, 0x24010005), then (addr 1, 0x08000C00), each 1 cycle after its 4th byte.
  - done=1 and cpu_run=1 the cycle after the second write; word_cnt=2; err=0.
- Bursty stream: same stream with s_valid toggled randomly (about 50% duty) -> identical writes and final state; no write issued early or duplicated.
- Zero length: start, send 00 00 00 00 -> no im_we; done=1 and cpu_run=1 one cycle after the 4th byte; word_cnt=0.
- Overflow with ADDR_WIDTH=2: N=6, words 0x11111111..0x66666666 -> writes at addr 0..3 only.
  - err=1 from the cycle after LEN completes.
  - word_cnt=6, done=1, cpu_run=1; s_ready=0 afterwards.
- Reset mid-word: after N=3 and 2 bytes of word 1, assert reset=0 asynchronously between edges -> outputs 0 immediately; no im_we.
  - After release plus start and a full N=1 load of 0xDEADBEEF: single write (addr 0, 0xDEADBEEF).
- Restart and ignored start: start pulses during DATA are ignored, with no change to word_cnt. A start in DONE drops cpu_run the next cycle, clears done, err and word_cnt, and a new load rewrites from addr 0.
